// File: rtl/ascon_pack.sv
// Shared constants, state encoding and helpers for the ASCON input scheduler.
package ascon_pack;

  localparam int unsigned DATA_W       = 64;
  localparam int unsigned NB_AD_BLOCKS = 1;
  localparam int unsigned NB_PT_BLOCKS = 4;
  localparam int unsigned NB_BLOCKS    = NB_AD_BLOCKS + NB_PT_BLOCKS;
  localparam int unsigned CNT_W        = 3;
  localparam int unsigned FIFO_DEPTH   = 2;
  localparam int unsigned FIFO_CNT_W   = 2;

  localparam logic [CNT_W-1:0] BLOCKS_PER_JOB = CNT_W'(NB_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_ACK,
    S_WAIT_END
  } sched_state_t;

  // Blocks past the associated-data prefix carry plaintext.
  function automatic logic is_pt_block(input logic [CNT_W-1:0] idx);
    return idx >= CNT_W'(NB_AD_BLOCKS);
  endfunction

endpackage

// File: rtl/ascon_fifo2.sv
// Two-entry shift-style FIFO; entry0 is always the head, so head_o is a plain register.
module ascon_fifo2
  import ascon_pack::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic [DATA_W-1:0]     head_o
);

  localparam logic [FIFO_CNT_W-1:0] DEPTH = FIFO_CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0]     entry0_q, entry0_d;
  logic [DATA_W-1:0]     entry1_q, entry1_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  full_q, empty_q;
  logic                  pop_ok, push_ok;

  // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + FIFO_CNT_W'(push_ok) - FIFO_CNT_W'(pop_ok);
      if (pop_ok) begin
        entry0_d = entry1_q;
      end
      if (push_ok) begin
        if ((count_q == '0) || ((count_q == FIFO_CNT_W'(1)) && pop_ok)) begin
          entry0_d = data_i;
        end else begin
          entry1_d = data_i;
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH);
      empty_q  <= (count_d == '0);
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
  assign head_o  = entry0_q;

endmodule

// File: rtl/ascon_input_scheduler.sv
// Buffers host words and hands them to the ASCON core one block at a time,
// keyed on the core's level-type wait signal.
module ascon_input_scheduler
  import ascon_pack::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic              core_wait_i,
  input  logic              core_end_i,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  bloc_o
);

  sched_state_t          state_q, state_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      accepted_q, accepted_d;
  logic [CNT_W-1:0]      bloc_q, bloc_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  start_q, start_d;
  logic                  dv_q, dv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_W-1:0]     fifo_head;
  logic                  issue_c, job_start_c;

  ascon_fifo2 u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush_i (abort_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (word_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Ready depends only on registered state, so a pop never reaches it combinationally.
  assign word_ready_o = busy_q
                     && (fifo_count < FIFO_CNT_W'(FIFO_DEPTH))
                     && (accepted_q < BLOCKS_PER_JOB);
  assign fifo_push    = word_valid_i && word_ready_o && !fifo_full;

  assign issue_c     = !abort_i && (state_q == S_FEED) && core_wait_i && !fifo_empty
                    && (issued_q < BLOCKS_PER_JOB);
  assign fifo_pop    = issue_c;
  assign job_start_c = (state_d == S_START);

  // State and registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      accepted_q <= '0;
      bloc_q     <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      bloc_q     <= bloc_d;
      data_q     <= data_d;
      start_q    <= start_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state; S_ACK waits for core_wait_i to drop so a held level issues only once.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:     if (start_i) state_d = S_START;
        S_START:    state_d = S_FEED;
        S_FEED:     if (issue_c) state_d = S_ACK;
        S_ACK: begin
          if (!core_wait_i) begin
            state_d = (issued_q == BLOCKS_PER_JOB) ? S_WAIT_END : S_FEED;
          end
        end
        S_WAIT_END: if (core_end_i) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Next values of outputs and job counters.
  always_comb begin
    start_d    = job_start_c;
    busy_d     = (state_d != S_IDLE);
    done_d     = !abort_i && (state_q == S_WAIT_END) && core_end_i;
    dv_d       = issue_c;
    data_d     = issue_c ? fifo_head : data_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    bloc_d     = bloc_q;
    if (abort_i || job_start_c) begin
      issued_d   = '0;
      accepted_d = '0;
      bloc_d     = '0;
    end else begin
      if (issue_c) begin
        issued_d = issued_q + CNT_W'(1);
        if (is_pt_block(issued_q)) begin
          bloc_d = bloc_q + CNT_W'(1);
        end
      end
      if (fifo_push) begin
        accepted_d = accepted_q + CNT_W'(1);
      end
    end
  end

  assign start_o      = start_q;
  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign bloc_o       = bloc_q;

endmodule

// File: tb/tb_ascon_input_scheduler.sv
// Bench for ascon_input_scheduler: cycle table for a full job plus scripted corner sequences,
// with a scoreboard pairing accepted host words against issued blocks.
module tb_ascon_input_scheduler;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        core_wait;
  logic        core_end;
  logic        start_p;
  logic [63:0] data;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic [2:0]  bloc;

  int          checks;
  int          errors;
  int          dv_cnt;
  logic [63:0] sb_q[$];

  typedef struct {
    logic        st;
    logic        ab;
    logic        wv;
    logic [63:0] w;
    logic        cw;
    logic        ce;
    logic        e_start;
    logic        e_dv;
    logic        e_busy;
    logic        e_done;
    logic        e_ready;
    logic [2:0]  e_bloc;
  } vec_t;

  vec_t vecs[15];

  ascon_input_scheduler dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .start_i      (start),
    .abort_i      (abort),
    .word_i       (word),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .core_wait_i  (core_wait),
    .core_end_i   (core_end),
    .start_o      (start_p),
    .data_o       (data),
    .data_valid_o (data_valid),
    .busy_o       (busy),
    .done_o       (done),
    .bloc_o       (bloc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic vec_t mk(input logic st, input logic ab, input logic wv, input logic [63:0] w,
                              input logic cw, input logic ce, input logic es, input logic edv,
                              input logic eb, input logic ed, input logic er, input logic [2:0] ebl);
    vec_t v;
    v.st = st; v.ab = ab; v.wv = wv; v.w = w; v.cw = cw; v.ce = ce;
    v.e_start = es; v.e_dv = edv; v.e_busy = eb; v.e_done = ed; v.e_ready = er; v.e_bloc = ebl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock cycle; the scoreboard looks at the bus mid-cycle, then outputs settle after the edge.
  task automatic tick();
    logic [63:0] exp_w;
    @(negedge clock);
    if (!reset && data_valid) begin
      dv_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_valid: data_o=%0h with no accepted word pending", data);
      end else begin
        exp_w = sb_q.pop_front();
        chk("sb_data_order", data, exp_w);
      end
    end
    if (!reset && word_valid && word_ready) sb_q.push_back(word);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; abort = 1'b0; word_valid = 1'b0; word = '0; core_wait = 1'b0; core_end = 1'b0;
  endtask

  task automatic run_table(input int pass);
    for (int i = 0; i < 15; i++) begin
      start = vecs[i].st; abort = vecs[i].ab; word_valid = vecs[i].wv;
      word = vecs[i].w; core_wait = vecs[i].cw; core_end = vecs[i].ce;
      tick();
      chk($sformatf("p%0d_row%0d_start", pass, i), 64'(start_p), 64'(vecs[i].e_start));
      chk($sformatf("p%0d_row%0d_dv", pass, i), 64'(data_valid), 64'(vecs[i].e_dv));
      chk($sformatf("p%0d_row%0d_busy", pass, i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("p%0d_row%0d_done", pass, i), 64'(done), 64'(vecs[i].e_done));
      chk($sformatf("p%0d_row%0d_ready", pass, i), 64'(word_ready), 64'(vecs[i].e_ready));
      chk($sformatf("p%0d_row%0d_bloc", pass, i), 64'(bloc), 64'(vecs[i].e_bloc));
    end
    clear_inputs();
    chk($sformatf("p%0d_sb_drained", pass), 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int n0;
    checks = 0; errors = 0; dv_cnt = 0;
    // Nominal job with a refused 6th word, stray start/end in S_FEED, and end-of-job done.
    //            st ab wv word cw ce   start dv busy done ready bloc
    vecs[0]  = mk(1, 0, 0, 64'h0, 0, 0,  1, 0, 1, 0, 1, 3'd0);
    vecs[1]  = mk(0, 0, 1, 64'h0, 0, 0,  0, 0, 1, 0, 1, 3'd0);
    vecs[2]  = mk(0, 0, 1, 64'h1, 1, 0,  0, 1, 1, 0, 1, 3'd0);
    vecs[3]  = mk(0, 0, 1, 64'h2, 0, 0,  0, 0, 1, 0, 0, 3'd0);
    vecs[4]  = mk(0, 0, 1, 64'h3, 1, 0,  0, 1, 1, 0, 1, 3'd1);
    vecs[5]  = mk(0, 0, 1, 64'h3, 0, 0,  0, 0, 1, 0, 0, 3'd1);
    vecs[6]  = mk(0, 0, 1, 64'h4, 1, 0,  0, 1, 1, 0, 1, 3'd2);
    vecs[7]  = mk(0, 0, 1, 64'h4, 0, 0,  0, 0, 1, 0, 0, 3'd2);
    vecs[8]  = mk(0, 0, 1, 64'h5, 1, 0,  0, 1, 1, 0, 0, 3'd3);
    vecs[9]  = mk(1, 0, 1, 64'h5, 0, 1,  0, 0, 1, 0, 0, 3'd3);
    vecs[10] = mk(0, 0, 1, 64'h5, 1, 0,  0, 1, 1, 0, 0, 3'd4);
    vecs[11] = mk(0, 0, 0, 64'h0, 0, 0,  0, 0, 1, 0, 0, 3'd4);
    vecs[12] = mk(0, 0, 0, 64'h0, 1, 0,  0, 0, 1, 0, 0, 3'd4);
    vecs[13] = mk(0, 0, 0, 64'h0, 0, 1,  0, 0, 0, 1, 0, 3'd4);
    vecs[14] = mk(0, 0, 0, 64'h0, 0, 0,  0, 0, 0, 0, 0, 3'd4);

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_start", 64'(start_p), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(word_ready), 64'd0);
    chk("rst_bloc", 64'(bloc), 64'd0);
    chk("rst_data", data, 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ready", 64'(word_ready), 64'd0);

    run_table(0);

    // Held core_wait: one issue only, then an empty FIFO stalls in S_FEED.
    start = 1'b1; tick(); start = 1'b0;
    word_valid = 1'b1; word = 64'hA5A5_0000_0000_00A5; tick(); word_valid = 1'b0;
    core_wait = 1'b1;
    n0 = dv_cnt;
    repeat (10) tick();
    chk("held_wait_single_issue", 64'(dv_cnt - n0), 64'd1);
    chk("held_wait_data", data, 64'hA5A5_0000_0000_00A5);
    core_wait = 1'b0; tick();
    chk("held_wait_back_to_feed_busy", 64'(busy), 64'd1);
    core_wait = 1'b1; tick();
    chk("empty_fifo_stall_dv", 64'(data_valid), 64'd0);
    core_end = 1'b1; tick(); core_end = 1'b0;
    chk("end_ignored_done", 64'(done), 64'd0);
    chk("end_ignored_busy", 64'(busy), 64'd1);
    abort = 1'b1; core_wait = 1'b0; tick(); abort = 1'b0;
    chk("abort1_busy", 64'(busy), 64'd0);
    chk("abort1_done", 64'(done), 64'd0);
    chk("abort1_data_kept", data, 64'hA5A5_0000_0000_00A5);

    // Backpressure with a third word, then abort after two issues.
    start = 1'b1; tick(); start = 1'b0;
    word_valid = 1'b1; word = 64'hB0; tick();
    word = 64'hB1; tick();
    chk("bp_full_after_two", 64'(word_ready), 64'd0);
    word = 64'hB2; tick();
    chk("bp_third_refused", 64'(word_ready), 64'd0);
    core_wait = 1'b1; tick();
    chk("bp_first_issue_dv", 64'(data_valid), 64'd1);
    chk("bp_first_issue_data", data, 64'hB0);
    chk("bp_ready_after_pop", 64'(word_ready), 64'd1);
    core_wait = 1'b0; tick();
    chk("bp_third_accepted", 64'(word_ready), 64'd0);
    word_valid = 1'b0; core_wait = 1'b1; tick();
    chk("bp_second_issue_data", data, 64'hB1);
    chk("bp_second_issue_bloc", 64'(bloc), 64'd1);
    core_wait = 1'b0; tick();
    abort = 1'b1; tick(); abort = 1'b0;
    sb_q.delete();
    chk("abort2_busy", 64'(busy), 64'd0);
    chk("abort2_bloc", 64'(bloc), 64'd0);
    chk("abort2_done", 64'(done), 64'd0);
    chk("abort2_ready", 64'(word_ready), 64'd0);
    chk("abort2_data_kept", data, 64'hB1);
    tick();
    chk("abort2_no_late_done", 64'(done), 64'd0);

    run_table(1);

    // Asynchronous reset in the middle of an S_ACK cycle.
    start = 1'b1; tick(); start = 1'b0;
    word_valid = 1'b1; word = 64'hC0; tick(); word_valid = 1'b0;
    core_wait = 1'b1; tick();
    chk("ack_dv_before_reset", 64'(data_valid), 64'd1);
    chk("ack_data_before_reset", data, 64'hC0);
    #2;
    reset = 1'b1;
    sb_q.delete();
    #1;
    chk("async_rst_start", 64'(start_p), 64'd0);
    chk("async_rst_dv", 64'(data_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_ready", 64'(word_ready), 64'd0);
    chk("async_rst_bloc", 64'(bloc), 64'd0);
    chk("async_rst_data", data, 64'd0);
    core_wait = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    chk("post_async_busy", 64'(busy), 64'd0);
    chk("post_async_done", 64'(done), 64'd0);

    run_table(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_input_scheduler.md
ASCON_INPUT_SCHEDULER -- requirements
Module: ascon_input_scheduler

Interface
REQ-001 SHALL have one clock and one reset: clock is single; reset is asynchronous and active-high.
REQ-002 clock_i  input  1  rising-edge clock.
REQ-003 reset_i  input  1  asynchronous active-high reset.
REQ-004 start_i  input  1  host job request; sampled only in S_IDLE.
REQ-005 abort_i  input  1  synchronous job abort.
REQ-006 word_i  input  64  host data word (AD first, then plaintext).
REQ-007 word_valid_i / word_ready_o  input / output  1 each  host push handshake; a transfer occurs when both are 1 on a clock edge.
REQ-008 core_wait_i  input  1  level from the core: the core is idle and waiting for a data block.
REQ-009 core_end_i  input  1  core end-of-job pulse (tag ready).
REQ-010 start_o  output  1  one-cycle start pulse to the core.
REQ-011 data_o  output  64  block presented to the core, registered.
REQ-012 data_valid_o  output  1  one-cycle block-valid pulse to the core.
REQ-013 busy_o / done_o  output  1 each  job active / one-cycle job-complete pulse.
REQ-014 bloc_o  output  3  number of plaintext blocks issued in the current job.

Function
REQ-015 States SHALL be: S_IDLE, S_START, S_FEED, S_ACK, S_WAIT_END.
REQ-016 S_IDLE SHALL go to S_START when start_i=1; S_START lasts one cycle and drives start_o=1.
REQ-017 S_START SHALL go to S_FEED.
REQ-018 S_FEED SHALL issue a block when core_wait_i=1 and the FIFO is non-empty.
REQ-019 Issuing a block SHALL pop the FIFO head into data_o, pulse data_valid_o for one cycle, and enter S_ACK.
REQ-020 data_valid_o and data_o SHALL update on the clock edge after the issue condition is seen (1-cycle latency).
REQ-021 data_o SHALL hold its value until the next issue, because the core absorbs the block several cycles after data_valid_o.
REQ-022 S_ACK SHALL wait for core_wait_i=0, then return to S_FEED; this prevents double issue on the level-type core_wait_i.
REQ-023 A job SHALL consist of exactly NB_AD_BLOCKS + NB_PT_BLOCKS = 5 blocks: block 0 is AD, blocks 1-4 are plaintext.
REQ-024 bloc_o SHALL increment on each plaintext issue, range 0..4, and clear on entry to S_START.
REQ-025 After the 5th issue, S_ACK SHALL go to S_WAIT_END once core_wait_i=0.
REQ-026 S_WAIT_END SHALL return to S_IDLE on core_end_i=1, pulsing done_o in that same transition.
REQ-027 The FIFO SHALL be 2-entry, 64 bits wide; word_ready_o = busy_o and fifo_count<2 and accepted<5 (no combinational path from pop).
REQ-028 The accepted counter SHALL be 3 bits, clear on S_START, saturate at 5; further words SHALL be refused (ready=0).
REQ-029 Simultaneous push and pop SHALL be legal; count is unchanged and order is preserved.
REQ-030 An empty FIFO while core_wait_i=1 SHALL stall in S_FEED with no pulse.
REQ-031 core_end_i outside S_WAIT_END SHALL be ignored.
REQ-032 start_i outside S_IDLE SHALL be ignored.
REQ-033 busy_o SHALL be 1 in every state except S_IDLE.
REQ-034 abort_i=1 in any state SHALL, at the next edge, flush the FIFO, clear the counters and bloc_o, and go to S_IDLE with no done_o; data_o is kept.

Reset
REQ-035 reset_i=1 SHALL immediately force S_IDLE, empty the FIFO, and zero the counters.
REQ-036 During reset, all outputs SHALL be 0, including data_o=64'h0 and word_ready_o=0.
REQ-037 Reset asserted mid-job SHALL behave as REQ-035/036 with no done_o.
REQ-038 The first edge after reset release SHALL be treated as S_IDLE.

Structure
REQ-039 NB_AD_BLOCKS=1, NB_PT_BLOCKS=4 and the scheduler state enum SHALL reside in ascon_pack.
REQ-040 The FIFO SHALL be a sub-module ascon_fifo2 (push, pop, full, empty, count, head data, async active-high reset, flush).
REQ-041 The scheduler SHALL contain no combinational path from core_wait_i to data_valid_o.

Verification
REQ-042 Nominal job: reset, start_i pulse, push 5 words 64'h0..04 with core_wait_i pulsed high per block -> start_o once, 5 data_valid_o pulses, data_o = 0..4 in order, bloc_o ends at 4, done_o on core_end_i.
REQ-043 Held wait: core_wait_i held high for 10 cycles after one issue -> exactly one data_valid_o pulse until core_wait_i drops.
REQ-044 Backpressure: 3 words offered before any issue -> word_ready_o=0 after 2 accepted; the 3rd word is accepted the cycle after the first pop.
REQ-045 Overrun: a 6th word offered -> word_ready_o stays 0; 6th word never appears on data_o.
REQ-046 Abort after 2 issues: abort_i pulse -> S_IDLE, bloc_o=0, no done_o; a new start_i runs a full nominal job correctly.
REQ-047 Async reset asserted mid-cycle during S_ACK -> all outputs 0 before the next clock edge.
